// File: rtl/wb_serial_master.sv
// -----------------------------------------------------------------------------
// wb_serial_master
//
// Wishbone classic master driven by a UART byte stream. A host sends
//   read : 0x01 A3 A2 A1 A0
//   write: 0x02 A3 A2 A1 A0 D3 D2 D1 D0      (all fields MSB first)
// and the block runs one 32-bit single Wishbone cycle. The response is
//   read : D3 D2 D1 D0 status
//   write: status
// where status is 0xAA on ack and 0xEE on err (or timeout).
//
// Optional feature: define WB_SERIAL_MASTER_TIMEOUT_EN to abort a bus cycle
// after timeout_cycles clocks without ack/err. When the macro is undefined,
// the bus phase waits forever and the timeout counter does not exist.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   rx_data, rx_valid     received byte and its one-cycle strobe
//   tx_data, tx_valid     response byte, held until tx_ready accepts it
//   tx_ready              transmitter ready
//   wb_*                  Wishbone classic master port (sel fixed at 4'hF)
//   busy                  high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module wb_serial_master #(
   parameter int timeout_cycles = 255   // legal range 1..65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      WDATA = 3'd2,
      BUS   = 3'd3,
      RESP  = 3'd4
   } state_t;

   localparam logic [7:0] CMD_READ   = 8'h01;
   localparam logic [7:0] CMD_WRITE  = 8'h02;
   localparam logic [7:0] STATUS_OK  = 8'hAA;
   localparam logic [7:0] STATUS_ERR = 8'hEE;

   state_t      state_reg;
   logic [2:0]  byte_cnt_reg;   // field byte index in ADDR/WDATA, response index in RESP
   logic [31:0] adr_reg;
   logic [31:0] dat_reg;
   logic        we_reg;
   logic        cyc_reg;
   logic [7:0]  status_reg;
   logic [7:0]  tx_data_reg;
   logic        tx_valid_reg;

   logic        bus_done;       // bus phase ends this cycle
   logic        bus_fail;       // ...and ends with error status
   logic [31:0] cap_data;       // data register value after the bus phase
   logic [7:0]  status_next;
   logic [2:0]  resp_idx_next;
   logic [7:0]  resp_byte_next;

`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(timeout_cycles);
   logic [15:0] timeout_cnt_reg;
   logic        timeout_hit;
   // Counter holds the number of BUS cycles already completed; the cycle in
   // which it would reach the limit is the last one with cyc/stb high.
   assign timeout_hit = ((timeout_cnt_reg + 16'd1) == TIMEOUT_LIMIT);
`endif

   // Completion decode: err beats ack, and any ack/err beats the timeout.
   always_comb begin
      bus_done = wb_ack_i | wb_err_i;
      bus_fail = wb_err_i;
`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
      if (timeout_hit && !wb_ack_i && !wb_err_i) begin
         bus_done = 1'b1;
         bus_fail = 1'b1;
      end
`endif
      if (bus_fail)
         cap_data = 32'h0;
      else if (we_reg)
         cap_data = dat_reg;
      else
         cap_data = wb_dat_i;
      status_next = bus_fail ? STATUS_ERR : STATUS_OK;
   end

   // Next response byte: indices 0..3 walk the data MSB first, 4 is status.
   always_comb begin
      resp_idx_next = byte_cnt_reg + 3'd1;
      case (resp_idx_next)
         3'd0:    resp_byte_next = dat_reg[31:24];
         3'd1:    resp_byte_next = dat_reg[23:16];
         3'd2:    resp_byte_next = dat_reg[15:8];
         3'd3:    resp_byte_next = dat_reg[7:0];
         default: resp_byte_next = status_reg;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         byte_cnt_reg <= 3'd0;
         adr_reg      <= 32'h0;
         dat_reg      <= 32'h0;
         we_reg       <= 1'b0;
         cyc_reg      <= 1'b0;
         status_reg   <= 8'h0;
         tx_data_reg  <= 8'h0;
         tx_valid_reg <= 1'b0;
`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
         timeout_cnt_reg <= 16'h0;
`endif
      end else begin
`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
         // Held at zero outside BUS, so it is clear on every BUS entry.
         timeout_cnt_reg <= 16'h0;
`endif
         case (state_reg)
            IDLE: begin
               if (rx_valid && (rx_data == CMD_READ || rx_data == CMD_WRITE)) begin
                  we_reg       <= rx_data[1];
                  byte_cnt_reg <= 3'd0;
                  state_reg    <= ADDR;
               end
            end

            ADDR: begin
               if (rx_valid) begin
                  adr_reg <= {adr_reg[23:0], rx_data};
                  if (byte_cnt_reg == 3'd3) begin
                     byte_cnt_reg <= 3'd0;
                     if (we_reg) begin
                        state_reg <= WDATA;
                     end else begin
                        state_reg <= BUS;
                        cyc_reg   <= 1'b1;
                     end
                  end else begin
                     byte_cnt_reg <= byte_cnt_reg + 3'd1;
                  end
               end
            end

            WDATA: begin
               if (rx_valid) begin
                  dat_reg <= {dat_reg[23:0], rx_data};
                  if (byte_cnt_reg == 3'd3) begin
                     byte_cnt_reg <= 3'd0;
                     state_reg    <= BUS;
                     cyc_reg      <= 1'b1;
                  end else begin
                     byte_cnt_reg <= byte_cnt_reg + 3'd1;
                  end
               end
            end

            BUS: begin
`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
               timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
`endif
               if (bus_done) begin
                  cyc_reg      <= 1'b0;
                  status_reg   <= status_next;
                  dat_reg      <= cap_data;
                  tx_valid_reg <= 1'b1;
                  state_reg    <= RESP;
                  // A write answers with the status byte only, so it starts
                  // at the status index.
                  if (we_reg) begin
                     byte_cnt_reg <= 3'd4;
                     tx_data_reg  <= status_next;
                  end else begin
                     byte_cnt_reg <= 3'd0;
                     tx_data_reg  <= cap_data[31:24];
                  end
               end
            end

            RESP: begin
               // tx_valid is always high here, so tx_ready alone is the accept.
               if (tx_ready) begin
                  if (byte_cnt_reg == 3'd4) begin
                     tx_valid_reg <= 1'b0;
                     byte_cnt_reg <= 3'd0;
                     state_reg    <= IDLE;
                  end else begin
                     byte_cnt_reg <= resp_idx_next;
                     tx_data_reg  <= resp_byte_next;
                  end
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign tx_data  = tx_data_reg;
   assign tx_valid = tx_valid_reg;
   assign wb_adr_o = adr_reg;
   assign wb_dat_o = dat_reg;
   assign wb_sel_o = 4'hF;
   assign wb_we_o  = we_reg;
   assign wb_cyc_o = cyc_reg;
   assign wb_stb_o = cyc_reg;
   assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_wb_serial_master.sv
// -----------------------------------------------------------------------------
// tb_wb_serial_master
//
// Directed bench for wb_serial_master: write, read, junk bytes with transmit
// backpressure, slave error, ack+err together, optional timeout, and reset
// during a command and during the bus phase. One line per transaction.
// -----------------------------------------------------------------------------
module tb_wb_serial_master;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_ack_i;
   logic        wb_err_i;
   logic        busy;

   int total_cnt = 0;
   int bad_cnt   = 0;

   localparam int MODE_ACK   = 0;
   localparam int MODE_ERR   = 1;
   localparam int MODE_BOTH  = 2;
   localparam int MODE_NEVER = 3;

   wb_serial_master #(.timeout_cycles(20)) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_dat_i (wb_dat_i),
      .wb_sel_o (wb_sel_o),
      .wb_we_o  (wb_we_o),
      .wb_cyc_o (wb_cyc_o),
      .wb_stb_o (wb_stb_o),
      .wb_ack_i (wb_ack_i),
      .wb_err_i (wb_err_i),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [39:0] got, input logic [39:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_read(input logic [31:0] adr);
      send_byte(8'h01);
      for (int i = 3; i >= 0; i--) send_byte(adr[8*i +: 8]);
   endtask

   task automatic send_write(input logic [31:0] adr, input logic [31:0] dat);
      send_byte(8'h02);
      for (int i = 3; i >= 0; i--) send_byte(adr[8*i +: 8]);
      for (int i = 3; i >= 0; i--) send_byte(dat[8*i +: 8]);
   endtask

   // Acts as the slave for one cycle: checks the request, waits 'delay'
   // cycles, then terminates according to 'mode'.
   task automatic bus_cycle(input string tag, input int mode, input int delay,
                            input logic [31:0] rdata, input logic [31:0] exp_adr,
                            input logic exp_we, input logic [31:0] exp_dat,
                            input int exp_len);
      int n;
      int hi;
      n = 0;
      while (!wb_cyc_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_val({tag, "_cyc_start"}, {39'd0, wb_cyc_o}, 40'd1);
      if (!wb_cyc_o) return;
      check_val({tag, "_req"}, {2'b0, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o},
                {2'b0, 1'b1, exp_we, 4'hF, exp_adr});
      if (exp_we) check_val({tag, "_wdat"}, {8'd0, wb_dat_o}, {8'd0, exp_dat});
      if (mode == MODE_NEVER) begin
         hi = 0;
         while (wb_cyc_o && hi < 300) begin
            @(negedge clk);
            hi++;
         end
         check_val({tag, "_cyc_len"}, 40'(hi), 40'(exp_len));
         return;
      end
      repeat (delay) @(negedge clk);
      check_val({tag, "_cyc_held"}, {38'd0, wb_cyc_o, wb_stb_o}, 40'd3);
      wb_dat_i = rdata;
      wb_ack_i = (mode == MODE_ACK || mode == MODE_BOTH);
      wb_err_i = (mode == MODE_ERR || mode == MODE_BOTH);
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = 32'h0;
      check_val({tag, "_cyc_drop"}, {38'd0, wb_cyc_o, wb_stb_o}, 40'd0);
   endtask

   // Collects n response bytes, stalling tx_ready for 'stall' cycles each;
   // expected bytes are packed MSB first in the low n bytes of exp.
   task automatic collect(input string tag, input int n, input int stall, input logic [39:0] exp);
      logic [7:0] b;
      int w;
      for (int i = 0; i < n; i++) begin
         w = 0;
         while (!tx_valid && w < 100) begin
            @(negedge clk);
            w++;
         end
         check_val($sformatf("%s_valid%0d", tag, i), {39'd0, tx_valid}, 40'd1);
         b = tx_data;
         check_val($sformatf("%s_byte%0d", tag, i), {32'd0, b}, {32'd0, exp[8*(n-1-i) +: 8]});
         if (stall > 0) begin
            repeat (stall) @(negedge clk);
            check_val($sformatf("%s_hold%0d", tag, i), {31'd0, tx_valid, tx_data},
                      {31'd0, 1'b1, exp[8*(n-1-i) +: 8]});
         end
         tx_ready = 1'b1;
         @(negedge clk);
         tx_ready = 1'b0;
      end
      repeat (3) @(negedge clk);
      check_val({tag, "_end"}, {38'd0, tx_valid, busy}, 40'd0);
      $display("txn %s: %0d response bytes collected", tag, n);
   endtask

   initial begin
      reset    = 1'b1;
      rx_data  = 8'h0;
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      wb_dat_i = 32'h0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      repeat (3) @(negedge clk);
      check_val("reset_ctl", {31'd0, tx_valid, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, busy},
                {31'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0});
      check_val("reset_adr", {8'd0, wb_adr_o}, 40'd0);
      check_val("reset_dat", {8'd0, wb_dat_o}, 40'd0);
      check_val("reset_txd", {32'd0, tx_data}, 40'd0);
      reset = 1'b0;
      $display("txn reset: outputs checked");

      // Write with ack after 3 cycles.
      send_write(32'h0000_0010, 32'hDEAD_BEEF);
      bus_cycle("wr", MODE_ACK, 3, 32'h0, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 0);
      collect("wr", 1, 0, 40'hAA);

      // Read with ack in the first bus cycle.
      send_read(32'h7000_0004);
      bus_cycle("rd", MODE_ACK, 0, 32'h1234_5678, 32'h7000_0004, 1'b0, 32'h0, 0);
      collect("rd", 5, 0, 40'h12_34_56_78_AA);

      // Junk command bytes then a read under heavy transmit backpressure.
      send_byte(8'h55);
      send_byte(8'hFF);
      @(negedge clk);
      check_val("junk_idle", {39'd0, busy}, 40'd0);
      send_read(32'h4000_0100);
      bus_cycle("bp", MODE_ACK, 2, 32'hA5C3_0F81, 32'h4000_0100, 1'b0, 32'h0, 0);
      collect("bp", 5, 10, 40'hA5_C3_0F_81_AA);

      // Slave error on a write and on a read; ack+err together is an error.
      send_write(32'h8000_0000, 32'h0102_0304);
      bus_cycle("wr_err", MODE_ERR, 1, 32'h0, 32'h8000_0000, 1'b1, 32'h0102_0304, 0);
      collect("wr_err", 1, 0, 40'hEE);
      send_read(32'h8000_0008);
      bus_cycle("rd_err", MODE_ERR, 0, 32'hFFFF_FFFF, 32'h8000_0008, 1'b0, 32'h0, 0);
      collect("rd_err", 5, 0, 40'h00_00_00_00_EE);
      send_read(32'h8000_000C);
      bus_cycle("rd_both", MODE_BOTH, 1, 32'hCAFE_F00D, 32'h8000_000C, 1'b0, 32'h0, 0);
      collect("rd_both", 5, 0, 40'h00_00_00_00_EE);

`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
      // Never-acking slave: abort after 20 bus cycles; a late ack is ignored.
      send_read(32'h9000_0000);
      bus_cycle("tmo", MODE_NEVER, 0, 32'h0, 32'h9000_0000, 1'b0, 32'h0, 20);
      wb_dat_i = 32'h1111_1111;
      wb_ack_i = 1'b1;
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0;
      collect("tmo", 5, 0, 40'h00_00_00_00_EE);
`endif

      // Reset after 3 address bytes.
      send_byte(8'h01);
      send_byte(8'h70);
      send_byte(8'h00);
      send_byte(8'h00);
      #2 reset = 1'b1;
      #1 check_val("rst_cmd", {38'd0, busy, wb_cyc_o}, 40'd0);
      @(negedge clk);
      reset = 1'b0;
      $display("txn rst_cmd: reset during address phase");

      // Reset in the middle of the bus phase.
      send_read(32'h2000_0000);
      check_val("rst_bus_pre", {39'd0, wb_cyc_o}, 40'd1);
      #2 reset = 1'b1;
      #1 check_val("rst_bus", {36'd0, wb_cyc_o, wb_stb_o, tx_valid, busy}, 40'd0);
      @(negedge clk);
      reset = 1'b0;
      $display("txn rst_bus: reset during bus phase");

      // Full read after the resets.
      send_read(32'h7000_0004);
      bus_cycle("post", MODE_ACK, 1, 32'h8765_4321, 32'h7000_0004, 1'b0, 32'h0, 0);
      collect("post", 5, 0, 40'h87_65_43_21_AA);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
